tabellone: RTL
==============

TABELLONE -- requirements
Module: tabellone

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock, shared with the manche stage.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 MANCHE  input  2  round result from the manche stage: 00 no round, 01 PRIMO wins, 10 SECONDO wins, 11 draw.
REQ-005 PARTITA  input  2  game result from the manche stage: 00 in progress, 01 PRIMO, 10 SECONDO, 11 draw; held until the next game starts.
REQ-006 AZZERA  input  1  synchronous clear of all totals and history.
REQ-007 LEGGI  input  1  pop request for the history FIFO.
REQ-008 VINTE_PRIMO  output  4  games won by PRIMO.
REQ-009 VINTE_SECONDO  output  4  games won by SECONDO.
REQ-010 PAREGGI  output  4  drawn games.
REQ-011 MANCHE_CORR  output  3  valid rounds (MANCHE != 00) in the current game.
REQ-012 STORICO  output  2  PARTITA code at the FIFO head; 00 when empty.
REQ-013 VALIDO  output  1  FIFO non-empty.
REQ-014 PIENO  output  1  FIFO holds 4 entries.
REQ-015 PERSO  output  1  sticky flag: a game result was dropped.

Function
REQ-016 All outputs SHALL be registered and change only after the clk edge that sampled the causing inputs (1-cycle latency).
REQ-017 FSM SHALL have states ATTESA, IN_GIOCO and FINE.
REQ-018 ATTESA -> IN_GIOCO when PARTITA == 00 and MANCHE != 00.
REQ-019 ATTESA or IN_GIOCO -> FINE when PARTITA != 00; this edge is the game-end event.
REQ-020 FINE -> ATTESA when PARTITA == 00.
REQ-021 In FINE, MANCHE SHALL be ignored and no counter SHALL change, so a held PARTITA is counted exactly once.
REQ-022 In ATTESA or IN_GIOCO, MANCHE != 00 SHALL increment MANCHE_CORR, including in the game-end cycle; the increment saturates at 7.
REQ-023 MANCHE_CORR SHALL clear to 0 on the FINE -> ATTESA transition.
REQ-024 On game-end, the counter selected by PARTITA (01 -> VINTE_PRIMO, 10 -> VINTE_SECONDO, 11 -> PAREGGI) SHALL increment by 1; each counter saturates at 15 with no wrap.
REQ-025 On game-end, the PARTITA code SHALL be pushed into a 4-entry FIFO with oldest-first output on STORICO.
REQ-026 A pop SHALL occur when LEGGI = 1 and VALIDO = 1; LEGGI on an empty FIFO SHALL be ignored.
REQ-027 Push when full without a pop: the entry is dropped, PERSO is set to 1, and the counters still increment.
REQ-028 Push and pop in the same cycle when full: both take effect, occupancy is unchanged, and PERSO is unchanged.
REQ-029 Push and pop in the same cycle when empty: the push completes and the pop is ignored.
REQ-030 FIFO pointers SHALL be 2 bits and wrap modulo 4; occupancy SHALL be a 3-bit count 0..4.
REQ-031 AZZERA = 1 SHALL, on the next edge, set all counters, the FIFO and PERSO to 0.
REQ-032 AZZERA = 1 SHALL send the FSM to FINE if PARTITA != 00, otherwise to ATTESA.
REQ-033 AZZERA SHALL override any simultaneous game-end, push or pop.

Reset
REQ-034 rst = 1 SHALL immediately force all outputs to 0 and the FSM to FINE, so a stale PARTITA is not counted; normal operation resumes on the first clk edge after rst falls.

Verification
REQ-035 Reset, then PARTITA = 00 for 1 cycle -> FSM in ATTESA, all outputs 0.
REQ-036 MANCHE 01, 11, 01 on 3 cycles with PARTITA = 01 in the third, then PARTITA held at 01 for 5 cycles -> MANCHE_CORR = 3, VINTE_PRIMO = 1 (not 6), STORICO = 01, VALIDO = 1.
REQ-037 5 games ending 10, 10, 11, 01, 10 with LEGGI = 0 -> PIENO = 1 after the 4th, PERSO = 1 after the 5th, VINTE_SECONDO = 3, STORICO = 10; then 4 LEGGI pulses -> STORICO reads 10, 10, 11, 01, then VALIDO = 0.
REQ-038 FIFO full, with LEGGI = 1 in the cycle of a game-end 11 -> occupancy stays 4, PERSO = 0, the new tail entry is 11.
REQ-039 16 PRIMO wins -> VINTE_PRIMO = 15 after the 15th and stays 15 after the 16th; 8 valid rounds in one game -> MANCHE_CORR = 7.
REQ-040 AZZERA while PARTITA = 10 is held -> counters 0, FIFO empty; no re-count until PARTITA returns to 00 and a new game ends.

Source files
------------

// File: rtl/tabellone.sv
// Scoreboard for the manche stage: per-game totals, round count in the
// current game and a 4-deep history FIFO of game results.
module tabellone (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  input  logic       AZZERA,
  input  logic       LEGGI,
  output logic [3:0] VINTE_PRIMO,
  output logic [3:0] VINTE_SECONDO,
  output logic [3:0] PAREGGI,
  output logic [2:0] MANCHE_CORR,
  output logic [1:0] STORICO,
  output logic       VALIDO,
  output logic       PIENO,
  output logic       PERSO
);

  typedef enum logic [1:0] {ATTESA, IN_GIOCO, FINE} stato_t;

  stato_t      stato_q, stato_d;
  logic [3:0]  vp_q, vp_d, vs_q, vs_d, par_q, par_d;
  logic [2:0]  mc_q, mc_d;
  logic [1:0]  mem_q [4];
  logic [1:0]  mem_d [4];
  logic [1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  storico_q, storico_d;
  logic        valido_q, valido_d, pieno_q, pieno_d, perso_q, perso_d;
  logic        fine_partita, push, pop;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  always_comb begin
    stato_d      = stato_q;
    vp_d         = vp_q;
    vs_d         = vs_q;
    par_d        = par_q;
    mc_d         = mc_q;
    mem_d        = mem_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    perso_d      = perso_q;
    fine_partita = 1'b0;
    push         = 1'b0;
    pop          = LEGGI && (cnt_q != 3'd0);

    case (stato_q)
      FINE: begin
        if (PARTITA == 2'b00) begin
          stato_d = ATTESA;
          mc_d    = '0;
        end
      end
      default: begin
        if (MANCHE != 2'b00 && mc_q != 3'd7) mc_d = mc_q + 3'd1;
        if (PARTITA != 2'b00) begin
          stato_d      = FINE;
          fine_partita = 1'b1;
        end else if (MANCHE != 2'b00) begin
          stato_d = IN_GIOCO;
        end
      end
    endcase

    if (fine_partita) begin
      case (PARTITA)
        2'b01:   vp_d  = sat_inc(vp_q);
        2'b10:   vs_d  = sat_inc(vs_q);
        default: par_d = sat_inc(par_q);
      endcase
      push = 1'b1;
    end

    if (pop) rd_d = rd_q + 2'd1;

    // When full, a simultaneous pop frees the slot the push reuses (wr == rd).
    if (push) begin
      if (cnt_q != 3'd4 || pop) begin
        mem_d[wr_q] = PARTITA;
        wr_d        = wr_q + 2'd1;
        if (!pop) cnt_d = cnt_q + 3'd1;
      end else begin
        perso_d = 1'b1;
      end
    end else if (pop) begin
      cnt_d = cnt_q - 3'd1;
    end

    if (AZZERA) begin
      stato_d = (PARTITA != 2'b00) ? FINE : ATTESA;
      vp_d    = '0;
      vs_d    = '0;
      par_d   = '0;
      mc_d    = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      perso_d = 1'b0;
    end

    storico_d = (cnt_d == 3'd0) ? 2'b00 : mem_d[rd_d];
    valido_d  = (cnt_d != 3'd0);
    pieno_d   = (cnt_d == 3'd4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stato_q   <= FINE;
      vp_q      <= '0;
      vs_q      <= '0;
      par_q     <= '0;
      mc_q      <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      storico_q <= '0;
      valido_q  <= 1'b0;
      pieno_q   <= 1'b0;
      perso_q   <= 1'b0;
    end else begin
      stato_q   <= stato_d;
      vp_q      <= vp_d;
      vs_q      <= vs_d;
      par_q     <= par_d;
      mc_q      <= mc_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      storico_q <= storico_d;
      valido_q  <= valido_d;
      pieno_q   <= pieno_d;
      perso_q   <= perso_d;
    end
  end

  assign VINTE_PRIMO   = vp_q;
  assign VINTE_SECONDO = vs_q;
  assign PAREGGI       = par_q;
  assign MANCHE_CORR   = mc_q;
  assign STORICO       = storico_q;
  assign VALIDO        = valido_q;
  assign PIENO         = pieno_q;
  assign PERSO         = perso_q;

endmodule
